// File: rtl/ram_dual_port_param.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with valid flag,
// 1- or 2-cycle read latency and selectable same-address read-during-write result.
module ram_dual_port_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int BYTE_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    localparam int NUM_BYTES   = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of BYTE_W");
        end
        if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
            $error("READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  collision;

    // The merged word is both what gets stored and the write-through value on a collision.
    assign wr_old = mem_q[write_addr];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign wr_merged[gi*BYTE_W +: BYTE_W] =
                be[gi] ? data[gi*BYTE_W +: BYTE_W] : wr_old[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst && we && (|be)) begin
            mem_q[write_addr] <= wr_merged;
        end
    end

    assign collision = we && (write_addr == read_addr);

    always_comb begin
        rd_word = mem_q[read_addr];
        if ((RDW_MODE == 1) && collision) begin
            rd_word = wr_merged;
        end
    end

    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_valid_d = re;
        if (re) begin
            s1_data_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
            logic                  s2_valid_q, s2_valid_d;

            // Second stage only advances on a valid slot so q holds between reads.
            always_comb begin
                s2_data_d  = s2_data_q;
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_d = s1_data_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s2_valid_d;
                end
            end

            assign q       = s2_data_q;
            assign q_valid = s2_valid_q;
        end else begin : g_lat1
            assign q       = s1_data_q;
            assign q_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dual_port_param.sv
// Directed bench: instance A uses default parameters (8-bit, latency 1, old-data collision),
// instance B is 32-bit, latency 2, write-through collision.
module tb_ram_dual_port_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_we = 1'b0, a_re = 1'b0;
    logic [5:0]  a_wa = '0, a_ra = '0;
    logic [7:0]  a_d = '0;
    logic [0:0]  a_be = '0;
    logic [7:0]  a_q;
    logic        a_v;

    logic        b_we = 1'b0, b_re = 1'b0;
    logic [5:0]  b_wa = '0, b_ra = '0;
    logic [31:0] b_d = '0;
    logic [3:0]  b_be = '0;
    logic [31:0] b_q;
    logic        b_v;

    int checks = 0;
    int errors = 0;

    ram_dual_port_param u_a (
        .clk(clk), .rst(rst), .we(a_we), .write_addr(a_wa), .data(a_d), .be(a_be),
        .re(a_re), .read_addr(a_ra), .q(a_q), .q_valid(a_v)
    );

    ram_dual_port_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .READ_LATENCY(2), .RDW_MODE(1)
    ) u_b (
        .clk(clk), .rst(rst), .we(b_we), .write_addr(b_wa), .data(b_d), .be(b_be),
        .re(b_re), .read_addr(b_ra), .q(b_q), .q_valid(b_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic a_wr(input logic [5:0] a, input logic [7:0] d, input logic m);
        a_we = 1'b1; a_wa = a; a_d = d; a_be = m;
        @(negedge clk);
        a_we = 1'b0;
    endtask

    task automatic b_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        b_we = 1'b1; b_wa = a; b_d = d; b_be = m;
        @(negedge clk);
        b_we = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_a_q", {24'h0, a_q}, 32'h0);
        chk("rst_a_v", {31'h0, a_v}, 32'h0);
        chk("rst_b_q", b_q, 32'h0);
        chk("rst_b_v", {31'h0, b_v}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // A: basic write then read with one-cycle latency
        a_wr(6'd3, 8'hA5, 1'b1);
        a_re = 1'b1; a_ra = 6'd3;
        @(negedge clk);
        a_re = 1'b0;
        chk("a_rd_q", {24'h0, a_q}, 32'hA5);
        chk("a_rd_v", {31'h0, a_v}, 32'h1);
        @(negedge clk);
        chk("a_hold_q", {24'h0, a_q}, 32'hA5);
        chk("a_hold_v", {31'h0, a_v}, 32'h0);

        // A: independent ports on the same edge
        a_wr(6'd2, 8'h22, 1'b1);
        a_we = 1'b1; a_wa = 6'd9; a_d = 8'h77; a_be = 1'b1;
        a_re = 1'b1; a_ra = 6'd2;
        @(negedge clk);
        a_we = 1'b0;
        chk("a_indep_q", {24'h0, a_q}, 32'h22);
        a_ra = 6'd9;
        @(negedge clk);
        a_re = 1'b0;
        chk("a_indep_rd9", {24'h0, a_q}, 32'h77);

        // A: collision returns old data
        a_wr(6'd5, 8'h0F, 1'b1);
        a_we = 1'b1; a_wa = 6'd5; a_d = 8'hF0; a_be = 1'b1;
        a_re = 1'b1; a_ra = 6'd5;
        @(negedge clk);
        a_we = 1'b0;
        chk("a_rdw_old", {24'h0, a_q}, 32'h0F);
        @(negedge clk);
        a_re = 1'b0;
        chk("a_rdw_after", {24'h0, a_q}, 32'hF0);

        // A: be=0 write is a no-op
        a_wr(6'd5, 8'h00, 1'b0);
        a_re = 1'b1; a_ra = 6'd5;
        @(negedge clk);
        a_re = 1'b0;
        chk("a_be0_noop", {24'h0, a_q}, 32'hF0);

        // B: byte-lane merge and two-cycle latency
        b_wr(6'd7, 32'h11223344, 4'hF);
        b_wr(6'd7, 32'hAABBCCDD, 4'b0101);
        b_re = 1'b1; b_ra = 6'd7;
        @(negedge clk);
        b_re = 1'b0;
        chk("b_lat_v0", {31'h0, b_v}, 32'h0);
        @(negedge clk);
        chk("b_merge_q", b_q, 32'h11BB33DD);
        chk("b_merge_v", {31'h0, b_v}, 32'h1);
        @(negedge clk);
        chk("b_merge_vlo", {31'h0, b_v}, 32'h0);

        // B: back-to-back pipelined reads
        for (int k = 0; k < 4; k++) begin
            b_wr(k[5:0], 32'(16 + k), 4'hF);
        end
        for (int k = 0; k < 6; k++) begin
            b_re = (k < 4);
            b_ra = k[5:0];
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                chk($sformatf("b_pipe_q%0d", k - 1), b_q, 32'(16 + k - 1));
                chk($sformatf("b_pipe_v%0d", k - 1), {31'h0, b_v}, 32'h1);
            end else begin
                chk($sformatf("b_pipe_idle%0d", k), {31'h0, b_v}, 32'h0);
            end
        end
        b_re = 1'b0;

        // B: collision returns merged word
        b_wr(6'd5, 32'h1234560F, 4'hF);
        b_we = 1'b1; b_wa = 6'd5; b_d = 32'hFFFFFFF0; b_be = 4'b0001;
        b_re = 1'b1; b_ra = 6'd5;
        @(negedge clk);
        b_we = 1'b0; b_re = 1'b0;
        @(negedge clk);
        chk("b_rdw_new", b_q, 32'h123456F0);
        b_re = 1'b1;
        @(negedge clk);
        b_re = 1'b0;
        @(negedge clk);
        chk("b_rdw_after", b_q, 32'h123456F0);

        // Reset mid-read: in-flight read dropped, memory kept, writes ignored during reset
        b_wr(6'd9, 32'hCAFEBABE, 4'hF);
        b_re = 1'b1; b_ra = 6'd9;
        @(negedge clk);
        b_re = 1'b0;
        #2 rst = 1'b1;
        a_we = 1'b1; a_wa = 6'd3; a_d = 8'h99; a_be = 1'b1;
        #1;
        chk("rst_async_bq", b_q, 32'h0);
        chk("rst_async_bv", {31'h0, b_v}, 32'h0);
        chk("rst_async_aq", {24'h0, a_q}, 32'h0);
        @(negedge clk);
        chk("rst_hold_bv", {31'h0, b_v}, 32'h0);
        a_we = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_late_v", {31'h0, b_v}, 32'h0);
        b_re = 1'b1; b_ra = 6'd9;
        a_re = 1'b1; a_ra = 6'd3;
        @(negedge clk);
        b_re = 1'b0; a_re = 1'b0;
        chk("rst_a_kept", {24'h0, a_q}, 32'hA5);
        @(negedge clk);
        chk("rst_b_kept_q", b_q, 32'hCAFEBABE);
        chk("rst_b_kept_v", {31'h0, b_v}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
